// File: rtl/int_math_unit.sv
// Integer math helpers: one's-complement abs, floor log2, iterative restoring square root.
// Define INT_MATH_SQRT_ROUND_EN to round the root to nearest (saturating) instead of truncating.
module int_math_unit #(
  parameter int unsigned ABS_W   = 16,
  parameter int unsigned SQRT_IW = 32
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic [ABS_W-1:0]       iAbsIn,
  output logic [ABS_W-1:0]       oAbs,
  input  logic [31:0]            iLogIn,
  output logic [4:0]             oLog,
  input  logic [SQRT_IW-1:0]     iSqrtIn,
  input  logic                   iStart,
  output logic [SQRT_IW/2-1:0]   oSqrt,
  output logic                   oBusy,
  output logic                   oDone
);

  localparam int unsigned N  = SQRT_IW / 2;
  localparam int unsigned RW = N + 2;
  localparam int unsigned CW = $clog2(N);

  logic [SQRT_IW-1:0] opndQ;
  logic [RW-1:0]      remQ;
  logic [N-1:0]       rootQ;
  logic [CW-1:0]      cntQ;

  logic [RW+1:0]      remShift;
  logic [RW+1:0]      trial;
  logic [RW+1:0]      remNext;
  logic [N-1:0]       rootNext;
  logic [N-1:0]       rootFinal;
  logic               unusedRemBits;

  assign oAbs = iAbsIn[ABS_W-1] ? ~iAbsIn : iAbsIn;

  always_comb begin
    oLog = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (iLogIn[i]) oLog = 5'(i);
    end
  end

  assign remShift = {remQ, opndQ[SQRT_IW-1 -: 2]};
  assign trial    = {2'b00, rootQ, 2'b01};

  always_comb begin
    if (remShift >= trial) begin
      remNext  = remShift - trial;
      rootNext = {rootQ[N-2:0], 1'b1};
    end else begin
      remNext  = remShift;
      rootNext = {rootQ[N-2:0], 1'b0};
    end
  end

  // The remainder never exceeds 2*root, so the top two bits are always zero.
  assign unusedRemBits = ^remNext[RW+1:RW];

`ifdef INT_MATH_SQRT_ROUND_EN
  always_comb begin
    rootFinal = rootNext;
    if ((remNext > {4'b0000, rootNext}) && (rootNext != '1)) rootFinal = rootNext + 1'b1;
  end
`else
  assign rootFinal = rootNext;
`endif

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      opndQ <= '0;
      remQ  <= '0;
      rootQ <= '0;
      cntQ  <= '0;
      oSqrt <= '0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      oDone <= 1'b0;
      if (oBusy) begin
        opndQ <= {opndQ[SQRT_IW-3:0], 2'b00};
        remQ  <= remNext[RW-1:0];
        rootQ <= rootNext;
        cntQ  <= cntQ + 1'b1;
        if (cntQ == CW'(N - 1)) begin
          oSqrt <= rootFinal;
          oDone <= 1'b1;
          oBusy <= 1'b0;
        end
      end else if (iStart) begin
        opndQ <= iSqrtIn;
        remQ  <= '0;
        rootQ <= '0;
        cntQ  <= '0;
        oBusy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_int_math_unit.sv
// Directed bench for int_math_unit: abs, log2 and the sqrt handshake including collision/reset.
module tb_int_math_unit;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [15:0] iAbsIn;
  logic [15:0] oAbs;
  logic [31:0] iLogIn;
  logic [4:0]  oLog;
  logic [31:0] iSqrtIn;
  logic        iStart;
  logic [15:0] oSqrt;
  logic        oBusy;
  logic        oDone;

  int total = 0;
  int bad   = 0;
  int lat;
  bit sawDone;

  int_math_unit #(.ABS_W(16), .SQRT_IW(32)) dut (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .iAbsIn  (iAbsIn),
    .oAbs    (oAbs),
    .iLogIn  (iLogIn),
    .oLog    (oLog),
    .iSqrtIn (iSqrtIn),
    .iStart  (iStart),
    .oSqrt   (oSqrt),
    .oBusy   (oBusy),
    .oDone   (oDone)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Caller sits at a negedge; the start is accepted at the following posedge.
  task automatic runSqrt(input logic [31:0] rad, input logic [15:0] expRoot, input string tag);
    logic [15:0] prev;
    int          n;
    int          busyN;
    bit          held;
    iSqrtIn = rad;
    iStart  = 1'b1;
    prev    = oSqrt;
    @(negedge iCLK);
    iStart = 1'b0;
    n      = 0;
    busyN  = 0;
    held   = 1'b1;
    while (!oDone && n < 40) begin
      if (oBusy) busyN++;
      if (oSqrt !== prev) held = 1'b0;
      @(negedge iCLK);
      n++;
    end
    check({tag, " latency"}, n, 16);
    check({tag, " busy cycles"}, busyN, 16);
    check({tag, " held"}, {31'd0, held}, 1);
    check({tag, " root"}, oSqrt, expRoot);
    check({tag, " busy at done"}, oBusy, 0);
    @(negedge iCLK);
    check({tag, " done pulse width"}, oDone, 0);
    check({tag, " root kept"}, oSqrt, expRoot);
  endtask

  initial begin
    iRST_N  = 1'b0;
    iStart  = 1'b1;
    iSqrtIn = 32'd12345;
    iAbsIn  = '0;
    iLogIn  = '0;

    // Combinational abs
    iAbsIn = 16'd1234;  #1 check("abs 1234", oAbs, 1234);
    iAbsIn = 16'hFFFB;  #1 check("abs -5", oAbs, 4);
    iAbsIn = 16'h8000;  #1 check("abs min", oAbs, 16'h7FFF);
    iAbsIn = 16'hFFFF;  #1 check("abs -1", oAbs, 0);

    // Combinational log2
    iLogIn = 32'd0;          #1 check("log 0", oLog, 0);
    iLogIn = 32'd1;          #1 check("log 1", oLog, 0);
    iLogIn = 32'd3;          #1 check("log 3", oLog, 1);
    iLogIn = 32'h0001_0000;  #1 check("log 2^16", oLog, 16);
    iLogIn = 32'hFFFF_FFFF;  #1 check("log max", oLog, 31);

    // Reset holds despite iStart
    repeat (2) @(negedge iCLK);
    check("rst sqrt", oSqrt, 0);
    check("rst busy", oBusy, 0);
    check("rst done", oDone, 0);
    iRST_N = 1'b1;
    iStart = 1'b0;
    @(negedge iCLK);
    check("idle busy", oBusy, 0);

    runSqrt(32'd1000000, 16'd1000, "sqrt 1e6");
`ifdef INT_MATH_SQRT_ROUND_EN
    runSqrt(32'd99, 16'd10, "sqrt 99");
`else
    runSqrt(32'd99, 16'd9, "sqrt 99");
`endif

    // Collision: start at +5 ignored, start held across completion edge ignored, +17 accepted
    iSqrtIn = 32'd1000000;
    iStart  = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    repeat (4) @(negedge iCLK);
    iSqrtIn = 32'd49;
    iStart  = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    check("coll busy", oBusy, 1);
    lat = 0;
    while (!oDone && lat < 40) begin
      @(negedge iCLK);
      lat++;
      if (lat == 10) iStart = 1'b1;
    end
    check("coll latency", lat, 11);
    check("coll root", oSqrt, 1000);
    check("coll busy at done", oBusy, 0);
    runSqrt(32'd49, 16'd7, "sqrt 49");

    // Reset mid-operation
    iSqrtIn = 32'd1000000;
    iStart  = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    repeat (7) @(negedge iCLK);
    iRST_N = 1'b0;
    @(negedge iCLK);
    check("midrst busy", oBusy, 0);
    check("midrst sqrt", oSqrt, 0);
    check("midrst done", oDone, 0);
    iRST_N  = 1'b1;
    sawDone = 1'b0;
    repeat (20) begin
      @(negedge iCLK);
      if (oDone) sawDone = 1'b1;
    end
    check("midrst no done", {31'd0, sawDone}, 0);
    check("midrst idle", oBusy, 0);

    runSqrt(32'd0, 16'd0, "sqrt 0");
    runSqrt(32'hFFFF_FFFF, 16'd65535, "sqrt max");
    runSqrt(32'd1000000, 16'd1000, "sqrt after rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
